// File: rtl/sine_phase_ctrl.sv
// Front-end sequencer for the CORDIC sine core: folds a full-circle phase into the
// first quadrant, drives the core, applies the quadrant sign and holds the result.
module sine_phase_ctrl #(
    parameter logic [15:0] HALF_PI     = 16'h6488,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic        Clk_i,
    input  logic        Rst_i,
    input  logic [15:0] Phase_i,
    input  logic        Valid_i,
    output logic        Ready_o,
    output logic [15:0] CoreAngle_o,
    output logic        CoreStart_o,
    input  logic [15:0] CoreSine_i,
    input  logic        CoreDone_i,
    output logic [15:0] Sine_o,
    output logic        Valid_o,
    input  logic        Ready_i,
    output logic        Err_o
);

    localparam int unsigned CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC,
        S_START,
        S_WAIT,
        S_OUT
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [15:0]    phase_q;
    logic           neg;
    logic [CW-1:0]  cnt;
    logic           timeout;
    logic [14:0]    red;
    logic [15:0]    sine_signed;

    always_comb begin
        timeout = (cnt == CW'(TIMEOUT_CYC - 1));
        // Odd quadrants run backwards, so mirror the in-quadrant offset about pi/2.
        red = phase_q[14] ? 15'(15'h4000 - {1'b0, phase_q[13:0]})
                          : {1'b0, phase_q[13:0]};
        if (!neg)
            sine_signed = CoreSine_i;
        else if (CoreSine_i == 16'h8000)
            sine_signed = 16'h7FFF;
        else
            sine_signed = 16'(~CoreSine_i + 16'd1);
    end

    always_ff @(posedge Clk_i or posedge Rst_i) begin
        if (Rst_i)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        Ready_o     = 1'b0;
        CoreStart_o = 1'b0;
        Valid_o     = 1'b0;
        case (state)
            S_IDLE: begin
                Ready_o = 1'b1;
                if (Valid_i)
                    state_nxt = S_CALC;
            end
            S_CALC:  state_nxt = S_START;
            S_START: begin
                CoreStart_o = 1'b1;
                state_nxt   = S_WAIT;
            end
            S_WAIT: begin
                if (CoreDone_i || timeout)
                    state_nxt = S_OUT;
            end
            S_OUT: begin
                Valid_o = 1'b1;
                if (Ready_i)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk_i or posedge Rst_i) begin
        if (Rst_i) begin
            phase_q     <= '0;
            neg         <= 1'b0;
            cnt         <= '0;
            CoreAngle_o <= '0;
            Sine_o      <= '0;
            Err_o       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (Valid_i)
                        phase_q <= Phase_i;
                end
                S_CALC: begin
                    CoreAngle_o <= 16'((31'(red) * 31'(HALF_PI)) >> 14);
                    neg         <= phase_q[15];
                end
                S_START: cnt <= '0;
                S_WAIT: begin
                    // Done takes priority over a timeout landing on the same edge.
                    if (CoreDone_i) begin
                        Sine_o <= sine_signed;
                        Err_o  <= 1'b0;
                    end else if (timeout) begin
                        Sine_o <= '0;
                        Err_o  <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_OUT: begin
                    if (Ready_i)
                        Err_o <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
